fp_normalize_round_pack: RTL and testbench

FP_NORMALIZE_ROUND_PACK -- requirements
Module: fp_normalize_round_pack

---
 rtl/fp_normalize_round_pack.sv | 135 +++++++++++++
 tb/tb_fp_normalize_round_pack.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_round_pack.sv
// Normalizes, rounds and packs an unrounded 57-bit mantissa/13-bit exponent
// result into an IEEE-754 double, with valid/acknowledge handshakes on both sides.
module fp_normalize_round_pack #(
    parameter int unsigned ROUND_NEAREST_EVEN = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        In_store_bit,
    input  logic        In_sign,
    input  logic [12:0] In_exponent,
    input  logic [56:0] In_mantissa,
    output logic        In_acknowledgment,
    input  logic        SUM_acknowledgment,
    output logic        SUM_store_bit,
    output logic [63:0] SUM
);

    typedef enum logic [2:0] {
        S_STORE_IN,
        S_NORMALIZE_0,
        S_NORMALIZE_1,
        S_DENORMALIZE,
        S_ROUND,
        S_PACK,
        S_SUM_OUTPUT
    } state_t;

    localparam logic signed [13:0] EMIN = -14'sd1022;
    localparam logic signed [13:0] EMAX = 14'sd1023;

    state_t             state_q;
    logic               ack_q;
    logic               valid_q;
    logic [63:0]        sum_q;
    logic               sign_q;
    logic signed [13:0] exp_q;
    logic [56:0]        man_q;

    logic               rnd_inc;
    logic [56:0]        rnd_man;
    logic [10:0]        exp_field;

    always_comb begin
        rnd_inc   = (ROUND_NEAREST_EVEN != 0) && man_q[2] && (man_q[1] | man_q[0] | man_q[3]);
        rnd_man   = man_q + (rnd_inc ? 57'd8 : 57'd0);
        exp_field = 11'(exp_q + 14'sd1023);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_STORE_IN;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            man_q   <= '0;
        end else begin
            case (state_q)
                S_STORE_IN: begin
                    if (In_store_bit && ack_q) begin
                        sign_q  <= In_sign;
                        exp_q   <= {In_exponent[12], In_exponent};
                        man_q   <= In_mantissa;
                        ack_q   <= 1'b0;
                        state_q <= S_NORMALIZE_0;
                    end else begin
                        ack_q <= 1'b1;
                    end
                end
                S_NORMALIZE_0: begin
                    if (man_q[56]) begin
                        man_q <= {1'b0, man_q[56:2], man_q[1] | man_q[0]};
                        exp_q <= exp_q + 14'sd1;
                    end
                    state_q <= S_NORMALIZE_1;
                end
                S_NORMALIZE_1: begin
                    if (!man_q[55] && (man_q != '0) && (exp_q > EMIN)) begin
                        man_q <= {man_q[55:0], 1'b0};
                        exp_q <= exp_q - 14'sd1;
                    end else begin
                        state_q <= S_DENORMALIZE;
                    end
                end
                S_DENORMALIZE: begin
                    // A zero mantissa skips the right shifts regardless of exponent.
                    if ((man_q != '0) && (exp_q < EMIN)) begin
                        man_q <= {1'b0, man_q[56:2], man_q[1] | man_q[0]};
                        exp_q <= exp_q + 14'sd1;
                    end else begin
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (rnd_man[56]) begin
                        man_q <= {1'b0, rnd_man[56:2], rnd_man[1] | rnd_man[0]};
                        exp_q <= exp_q + 14'sd1;
                    end else begin
                        man_q <= rnd_man;
                    end
                    state_q <= S_PACK;
                end
                S_PACK: begin
                    if (man_q == '0) begin
                        sum_q <= {sign_q, 63'h0};
                    end else if (exp_q > EMAX) begin
                        sum_q <= {sign_q, 11'h7FF, 52'h0};
                    end else if (!man_q[55]) begin
                        sum_q <= {sign_q, 11'h000, man_q[54:3]};
                    end else begin
                        sum_q <= {sign_q, exp_field, man_q[54:3]};
                    end
                    valid_q <= 1'b1;
                    state_q <= S_SUM_OUTPUT;
                end
                S_SUM_OUTPUT: begin
                    if (SUM_acknowledgment) begin
                        valid_q <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= S_STORE_IN;
                    end
                end
                default: begin
                    state_q <= S_STORE_IN;
                end
            endcase
        end
    end

    assign In_acknowledgment = ack_q;
    assign SUM_store_bit     = valid_q;
    assign SUM               = sum_q;

endmodule

// File: tb/tb_fp_normalize_round_pack.sv
// Scoreboard bench: a driver issues operands and queues reference results,
// a monitor pops and compares each SUM when SUM_store_bit appears.
module tb_fp_normalize_round_pack;

    localparam int unsigned RNE = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        In_store_bit;
    logic        In_sign;
    logic [12:0] In_exponent;
    logic [56:0] In_mantissa;
    logic        In_acknowledgment;
    logic        SUM_acknowledgment;
    logic        SUM_store_bit;
    logic [63:0] SUM;

    always #5 clk = ~clk;

    fp_normalize_round_pack #(
        .ROUND_NEAREST_EVEN(RNE)
    ) dut (
        .Clock             (clk),
        .Reset             (rst),
        .In_store_bit      (In_store_bit),
        .In_sign           (In_sign),
        .In_exponent       (In_exponent),
        .In_mantissa       (In_mantissa),
        .In_acknowledgment (In_acknowledgment),
        .SUM_acknowledgment(SUM_acknowledgment),
        .SUM_store_bit     (SUM_store_bit),
        .SUM               (SUM)
    );

    typedef struct {
        logic [63:0] sum;
        int          lat;
        int          acc_cyc;
        bit          stall;
    } exp_t;

    typedef struct {
        bit          sgn;
        int          ex;
        logic [56:0] m;
        logic [63:0] sum;
        int          lat;
        bit          stall;
    } dir_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Exact value m * 2^(ex-55) rounded onto the double grid; latency from the shift rules.
    function automatic void ref_model(input bit sgn, input int ex, input logic [56:0] m,
                                      output logic [63:0] sum, output int shifts);
        int p, e, E, s, left, x;
        logic [127:0] q, rem, half;
        bit up;
        if (m == '0) begin
            sum    = {sgn, 63'h0};
            shifts = 0;
            return;
        end
        p = 0;
        for (int i = 0; i < 57; i++) if (m[i]) p = i;
        e  = ex + p - 55;
        E  = (e > -1022) ? e : -1022;
        s  = E - ex + 3;
        up = 0;
        q  = '0;
        if (s <= 0) begin
            q = {71'h0, m} << (-s);
        end else if (s <= 100) begin
            q    = {71'h0, m} >> s;
            rem  = {71'h0, m} & ((128'd1 << s) - 128'd1);
            half = 128'd1 << (s - 1);
            up   = (rem > half) || ((rem == half) && q[0]);
        end
        if ((RNE != 0) && up) q = q + 128'd1;
        if (q[53]) begin
            q = q >> 1;
            E++;
        end
        if (q == '0)       sum = {sgn, 63'h0};
        else if (E > 1023) sum = {sgn, 11'h7FF, 52'h0};
        else if (!q[52])   sum = {sgn, 11'h000, q[51:0]};
        else               sum = {sgn, 11'(E + 1023), q[51:0]};
        left = 0;
        if (p == 56) begin
            x = ex + 1;
        end else begin
            if (ex > -1022) left = ((55 - p) < (ex + 1022)) ? (55 - p) : (ex + 1022);
            x = ex - left;
        end
        shifts = left + ((x < -1022) ? (-1022 - x) : 0);
    endfunction

    task automatic send(input bit sgn, input int ex, input logic [56:0] m,
                        input logic [63:0] want, input int lat, input bit stall);
        int   n;
        exp_t t;
        n = 0;
        while (!In_acknowledgment && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!In_acknowledgment) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: In_acknowledgment got 0 expected 1 within 1000 cycles");
            return;
        end
        In_sign      = sgn;
        In_exponent  = 13'(ex);
        In_mantissa  = m;
        In_store_bit = 1'b1;
        @(posedge clk); #1;
        In_store_bit = 1'b0;
        chk("ack_low_after_accept", 64'(In_acknowledgment), 64'd0);
        t.sum     = want;
        t.lat     = lat;
        t.acc_cyc = cyc;
        t.stall   = stall;
        sb.push_back(t);
    endtask

    task automatic send_rand();
        logic [63:0] r64;
        logic [56:0] m;
        logic [63:0] want;
        int          ex, lat;
        bit          sgn;
        r64 = {$urandom(), $urandom()};
        m   = r64[56:0] >> $urandom_range(0, 56);
        if ($urandom_range(0, 3) == 0) m[2:0] = 3'b100;
        if ($urandom_range(0, 15) == 0) m = '0;
        case ($urandom_range(0, 3))
            0:       ex = int'($urandom_range(0, 120)) - 60;
            1:       ex = int'($urandom_range(0, 90)) - 1090;
            2:       ex = int'($urandom_range(0, 20)) + 1010;
            default: ex = int'($urandom_range(0, 6)) - 3;
        endcase
        sgn = 1'($urandom_range(0, 1));
        ref_model(sgn, ex, m, want, lat);
        send(sgn, ex, m, want, 5 + lat, 1'b0);
    endtask

    initial begin : monitor
        exp_t        t;
        logic [63:0] held;
        int          hold;
        SUM_acknowledgment = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (SUM_store_bit) begin
                hold = 0;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got SUM %h expected no output", SUM);
                end else begin
                    t = sb.pop_front();
                    chk("sum", SUM, t.sum);
                    chk("latency", 64'(cyc - t.acc_cyc), 64'(t.lat));
                    hold = t.stall ? 10 : int'($urandom_range(0, 3));
                end
                held = SUM;
                for (int k = 0; k < hold; k++) begin
                    @(posedge clk); #1;
                    chk("stall_sum_stable", SUM, held);
                    chk("stall_valid_high", 64'(SUM_store_bit), 64'd1);
                    chk("stall_ack_low", 64'(In_acknowledgment), 64'd0);
                end
                SUM_acknowledgment = 1'b1;
                @(posedge clk); #1;
                SUM_acknowledgment = 1'b0;
                chk("valid_cleared", 64'(SUM_store_bit), 64'd0);
                chk("ack_after_handshake", 64'(In_acknowledgment), 64'd1);
            end
        end
    end

    initial begin : driver
        dir_t dir[8];
        int   n;
        rst          = 1'b1;
        In_store_bit = 1'b0;
        In_sign      = 1'b0;
        In_exponent  = '0;
        In_mantissa  = '0;

        dir[0] = '{1'b0,     0, 57'h100_0000_0000_0000, 64'h4000000000000000,  5, 1'b0};
        dir[1] = '{1'b0,     0, 57'h000_0000_0000_0008, 64'h3CB0000000000000, 57, 1'b0};
        dir[2] = '{1'b0,     0, 57'h080_0000_0000_000C, 64'h3FF0000000000002,  5, 1'b1};
        dir[3] = '{1'b0,     0, 57'h080_0000_0000_0004, 64'h3FF0000000000000,  5, 1'b0};
        dir[4] = '{1'b0,     0, 57'h0FF_FFFF_FFFF_FFFC, 64'h4000000000000000,  5, 1'b0};
        dir[5] = '{1'b1,  1023, 57'h100_0000_0000_0000, 64'hFFF0000000000000,  5, 1'b0};
        dir[6] = '{1'b0, -1023, 57'h080_0000_0000_0000, 64'h0008000000000000,  6, 1'b0};
        dir[7] = '{1'b1,     0, 57'h000_0000_0000_0000, 64'h8000000000000000,  5, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", 64'(In_acknowledgment), 64'd0);
        chk("reset_valid", 64'(SUM_store_bit), 64'd0);
        chk("reset_sum", SUM, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ack_after_reset", 64'(In_acknowledgment), 64'd1);

        foreach (dir[i]) send(dir[i].sgn, dir[i].ex, dir[i].m, dir[i].sum, dir[i].lat, dir[i].stall);

        // Reset in the middle of the 52-step left-shift sequence drops the operand.
        send(1'b0, 0, 57'h8, 64'h3CB0000000000000, 57, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset_valid", 64'(SUM_store_bit), 64'd0);
        chk("midreset_sum", SUM, 64'd0);
        chk("midreset_ack", 64'(In_acknowledgment), 64'd0);
        sb.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ack_after_midreset", 64'(In_acknowledgment), 64'd1);
        repeat (60) @(posedge clk);
        #1;

        repeat (150) send_rand();

        n = 0;
        while ((sb.size() != 0 || !In_acknowledgment) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || !In_acknowledgment) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
